if_fetch_unit: RTL and testbench

Instruction-fetch controller for the pipelined MIPS core. It reads the current PC from the 32-bit PC register and fetches the instruction from instruction memory over a req/ack handshake. It presents the instruction to the decode stage and drives the PC register's D/CE inputs for sequential advance, branch/jump redirect and exception vectoring. It is the consumer/driver on the other side of the PC register, which resets to 0xBFC00000.

---
 rtl/if_fetch_unit.sv | 120 ++++++++++++
 tb/tb_if_fetch_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch controller: PC register driver, imem req/ack fetch, decode hand-off.
// if_valid rises the cycle after imem_ack; id_stall holds the word in HOLD, and imem_req waits on imem_ack.
module if_fetch_unit #(
  parameter logic [31:0] RESET_VEC = 32'hBFC0_0000,
  parameter logic [31:0] EXC_VEC   = 32'hBFC0_0380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_q,
  output logic [31:0] pc_d,
  output logic        pc_ce,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        exc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        adel,
  output logic [31:0] badvaddr
);

  typedef enum logic [1:0] {FETCH, HOLD, FLUSH} state_t;

  state_t      state;
  logic [31:0] flush_addr;
  logic        aligned;
  logic        take;

  assign aligned = (pc_q[1:0] == 2'b00);
  assign take    = exc | redirect;

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_q;
    pc_ce     = 1'b0;
    pc_d      = pc_q + 32'd4;
    if (!rst) begin
      case (state)
        FETCH:   imem_req = aligned;
        FLUSH: begin
          imem_req  = 1'b1;
          imem_addr = flush_addr;
        end
        default: imem_req = 1'b0;
      endcase
      if (take) begin
        pc_ce = 1'b1;
        pc_d  = exc ? EXC_VEC : redirect_pc;
      end else if (state == FETCH) begin
        if (!aligned) begin
          pc_ce = 1'b1;
          pc_d  = EXC_VEC;
        end else if (imem_ack) begin
          pc_ce = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      if_valid   <= 1'b0;
      if_instr   <= 32'h0;
      if_pc      <= RESET_VEC;
      adel       <= 1'b0;
      badvaddr   <= 32'h0;
      flush_addr <= 32'h0;
    end else begin
      adel <= 1'b0;
      if (take) begin
        if_valid <= 1'b0;
        case (state)
          // An outstanding request must complete at its original address.
          FETCH: begin
            if (aligned && !imem_ack) begin
              flush_addr <= pc_q;
              state      <= FLUSH;
            end else begin
              state <= FETCH;
            end
          end
          HOLD:    state <= FETCH;
          FLUSH:   state <= imem_ack ? FETCH : FLUSH;
          default: state <= FETCH;
        endcase
      end else begin
        case (state)
          FETCH: begin
            if (!aligned) begin
              adel     <= 1'b1;
              badvaddr <= pc_q;
            end else if (imem_ack) begin
              if_instr <= imem_rdata;
              if_pc    <= pc_q;
              if_valid <= 1'b1;
              state    <= HOLD;
            end
          end
          HOLD: begin
            if (!id_stall) begin
              if_valid <= 1'b0;
              state    <= FETCH;
            end
          end
          FLUSH: begin
            if (imem_ack) state <= FETCH;
          end
          default: state <= FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a PC register and a wait-state memory model around it.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        pc_ce;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        exc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        adel;
  logic [31:0] badvaddr;

  int          n_cmp = 0;
  int          n_err = 0;
  int          mem_wait;
  int          ce_cnt;
  logic [2:0]  mem_cnt;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk(clk), .rst(rst), .pc_q(pc_q), .pc_d(pc_d), .pc_ce(pc_ce),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .id_stall(id_stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .exc(exc), .if_valid(if_valid),
    .if_instr(if_instr), .if_pc(if_pc), .adel(adel), .badvaddr(badvaddr)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'hBFC0_0000: return 32'h2408_0001;
      32'hBFC0_0004: return 32'h2409_0002;
      default:       return a ^ 32'h1234_5678;
    endcase
  endfunction

  // PC register on the far side of pc_d/pc_ce
  always @(posedge clk) begin
    if (rst)        pc_q <= 32'hBFC0_0000;
    else if (pc_ce) pc_q <= pc_d;
  end

  always @(posedge clk) begin
    if (rst || !imem_req || imem_ack) mem_cnt <= 3'd0;
    else                              mem_cnt <= mem_cnt + 3'd1;
  end

  assign imem_ack   = imem_req && (int'(mem_cnt) >= mem_wait);
  assign imem_rdata = mem_word(imem_addr);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; id_stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    exc = 1'b0; mem_wait = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", imem_req, 1'b0);
    chk("rst_ce", pc_ce, 1'b0);
    chk("rst_valid", if_valid, 1'b0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_ifpc", if_pc, 32'hBFC0_0000);
    chk("rst_adel", adel, 1'b0);
    chk("rst_badv", badvaddr, 32'h0);

    // zero-wait memory, two sequential fetches
    @(negedge clk); rst = 1'b0; #1;
    chk("t1_req", imem_req, 1'b1);
    chk("t1_addr", imem_addr, 32'hBFC0_0000);
    chk("t1_ce", pc_ce, 1'b1);
    chk("t1_pcd", pc_d, 32'hBFC0_0004);
    @(negedge clk); #1;
    chk("t1_valid", if_valid, 1'b1);
    chk("t1_instr", if_instr, 32'h2408_0001);
    chk("t1_ifpc", if_pc, 32'hBFC0_0000);
    chk("t1_hold_req", imem_req, 1'b0);
    chk("t1_hold_ce", pc_ce, 1'b0);
    @(negedge clk); #1;
    chk("t1_valid2_lo", if_valid, 1'b0);
    chk("t1_addr2", imem_addr, 32'hBFC0_0004);
    chk("t1_ce2", pc_ce, 1'b1);
    chk("t1_pcd2", pc_d, 32'hBFC0_0008);
    @(negedge clk); mem_wait = 3; #1;
    chk("t1_valid2", if_valid, 1'b1);
    chk("t1_instr2", if_instr, 32'h2409_0002);
    chk("t1_ifpc2", if_pc, 32'hBFC0_0004);

    // three wait states, then id_stall for two cycles in HOLD
    ce_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) id_stall = 1'b1;
      #1;
      chk("t2_req", imem_req, 1'b1);
      chk("t2_addr", imem_addr, 32'hBFC0_0008);
      chk("t2_ce", pc_ce, (i == 3));
      chk("t2_valid", if_valid, 1'b0);
      ce_cnt += int'(pc_ce);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 2) id_stall = 1'b0;
      #1;
      chk("t2_hold_valid", if_valid, 1'b1);
      chk("t2_hold_instr", if_instr, 32'hADF4_5670);
      chk("t2_hold_ifpc", if_pc, 32'hBFC0_0008);
      ce_cnt += int'(pc_ce);
    end
    chk("t2_ce_count", ce_cnt, 32'd1);

    // redirect two cycles into a wait: old address completes, data dropped
    @(negedge clk); #1;
    chk("t3_addr0", imem_addr, 32'hBFC0_000C);
    chk("t3_ce0", pc_ce, 1'b0);
    @(negedge clk); #1;
    chk("t3_addr1", imem_addr, 32'hBFC0_000C);
    @(negedge clk); redirect = 1'b1; redirect_pc = 32'hBFC0_0100; #1;
    chk("t3_rd_ce", pc_ce, 1'b1);
    chk("t3_rd_pcd", pc_d, 32'hBFC0_0100);
    chk("t3_rd_addr", imem_addr, 32'hBFC0_000C);
    @(negedge clk); redirect = 1'b0; #1;
    chk("t3_fl_req", imem_req, 1'b1);
    chk("t3_fl_addr", imem_addr, 32'hBFC0_000C);
    chk("t3_fl_ce", pc_ce, 1'b0);
    chk("t3_fl_valid", if_valid, 1'b0);
    @(negedge clk); mem_wait = 0; #1;
    chk("t3_nv_valid", if_valid, 1'b0);
    chk("t3_new_addr", imem_addr, 32'hBFC0_0100);
    chk("t3_new_pcd", pc_d, 32'hBFC0_0104);

    // exc and redirect together in HOLD
    @(negedge clk); exc = 1'b1; redirect = 1'b1; redirect_pc = 32'h1234_5678; #1;
    chk("t4_valid", if_valid, 1'b1);
    chk("t4_ifpc", if_pc, 32'hBFC0_0100);
    chk("t4_instr", if_instr, 32'hADF4_5778);
    chk("t4_ce", pc_ce, 1'b1);
    chk("t4_pcd", pc_d, 32'hBFC0_0380);
    @(negedge clk); exc = 1'b0; redirect = 1'b0; #1;
    chk("t4_drop", if_valid, 1'b0);
    chk("t4_addr", imem_addr, 32'hBFC0_0380);
    @(negedge clk); #1;
    chk("t4_ifpc2", if_pc, 32'hBFC0_0380);
    chk("t4_instr2", if_instr, 32'hADF4_55F8);

    // misaligned redirect target raises adel
    redirect = 1'b1; redirect_pc = 32'hBFC0_0102; #1;
    chk("t5_pcd", pc_d, 32'hBFC0_0102);
    @(negedge clk); redirect = 1'b0; #1;
    chk("t5_req", imem_req, 1'b0);
    chk("t5_ce", pc_ce, 1'b1);
    chk("t5_pcd_exc", pc_d, 32'hBFC0_0380);
    chk("t5_adel_pre", adel, 1'b0);
    @(negedge clk); #1;
    chk("t5_adel", adel, 1'b1);
    chk("t5_badv", badvaddr, 32'hBFC0_0102);
    chk("t5_addr", imem_addr, 32'hBFC0_0380);
    chk("t5_req2", imem_req, 1'b1);
    @(negedge clk); #1;
    chk("t5_adel_off", adel, 1'b0);
    chk("t5_ifpc", if_pc, 32'hBFC0_0380);

    // PC wrap, then reset during a wait
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
    chk("t6_rd_pcd", pc_d, 32'hFFFF_FFFC);
    @(negedge clk); redirect = 1'b0; #1;
    chk("t6_addr", imem_addr, 32'hFFFF_FFFC);
    chk("t6_ce", pc_ce, 1'b1);
    chk("t6_wrap", pc_d, 32'h0000_0000);
    @(negedge clk); mem_wait = 3; #1;
    chk("t6_ifpc", if_pc, 32'hFFFF_FFFC);
    chk("t6_instr", if_instr, 32'hEDCB_A984);
    @(negedge clk); #1;
    chk("t6_addr0", imem_addr, 32'h0000_0000);
    chk("t6_req0", imem_req, 1'b1);
    @(negedge clk); rst = 1'b1; #1;
    chk("t6_rst_req", imem_req, 1'b0);
    chk("t6_rst_ce", pc_ce, 1'b0);
    @(negedge clk); #1;
    chk("t6_rst_valid", if_valid, 1'b0);
    chk("t6_rst_ifpc", if_pc, 32'hBFC0_0000);
    @(negedge clk); rst = 1'b0; #1;
    chk("t6_restart_req", imem_req, 1'b1);
    chk("t6_restart_addr", imem_addr, 32'hBFC0_0000);
    chk("t6_restart_ce", pc_ce, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
